// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl
// ---------------------
// Multi-cycle control sequencer for the LEGv8 datapath. Each instruction is
// stepped through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The FSM state,
// the latched instruction class and the sticky illegal flag are registered.
// All datapath enables are decoded combinationally from those registers plus
// mem_ready and zero, so an asynchronous reset clears them immediately.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   run            start/continue execution, sampled at instruction boundaries
//   opcode         instr[31:21] from the instruction register
//   mem_ready      memory access complete (used in FETCH and MEM only)
//   zero           ALU zero flag (used in EXEC of CBZ only)
//   state          current state encoding
//   pc_write, pc_src, ir_write, alu_src, alu_op, reg2loc,
//   mem_read, mem_write, mem_to_reg, reg_write   datapath controls
//   illegal        sticky illegal-opcode flag
//
// Optional feature (macro CTRL_PERF_CNT_EN): adds cycle_count and instr_count
// performance counters as extra output ports.

module legv8_multicycle_ctrl #(
  parameter int OPC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic [2:0]       state,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg2loc,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_count,
  output logic [31:0]      instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_UNUSED = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE  = 3'd0,
    CL_LDUR  = 3'd1,
    CL_STUR  = 3'd2,
    CL_RTYPE = 3'd3,
    CL_CBZ   = 3'd4,
    CL_B     = 3'd5
  } cls_t;

  localparam logic [OPC_W-1:0] OP_LDUR = OPC_W'(11'b11111000010);
  localparam logic [OPC_W-1:0] OP_STUR = OPC_W'(11'b11111000000);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(11'b10001011000);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(11'b11001011000);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(11'b10001010000);
  localparam logic [OPC_W-1:0] OP_ORR  = OPC_W'(11'b10101010000);

  // Map an opcode to its instruction class; CL_NONE marks an illegal opcode.
  function automatic cls_t decode_op(input logic [OPC_W-1:0] op);
    cls_t c;
    c = CL_NONE;
    if (op == OP_LDUR) begin
      c = CL_LDUR;
    end else if (op == OP_STUR) begin
      c = CL_STUR;
    end else if ((op == OP_ADD) || (op == OP_SUB) ||
                 (op == OP_AND) || (op == OP_ORR)) begin
      c = CL_RTYPE;
    end else if (op[OPC_W-1 -: 8] == 8'b10110100) begin
      c = CL_CBZ;
    end else if (op[OPC_W-1 -: 6] == 6'b000101) begin
      c = CL_B;
    end else begin
      c = CL_NONE;
    end
    return c;
  endfunction

  state_t state_r;
  cls_t   class_r;
  logic   illegal_r;
  cls_t   dec_s;
  logic   retire_s;

  // Opcode decode and instruction-retire detection.
  always_comb begin
    dec_s    = decode_op(opcode);
    retire_s = 1'b0;
    case (state_r)
      S_EXEC:  retire_s = (class_r == CL_B) || (class_r == CL_CBZ);
      S_MEM:   retire_s = (class_r == CL_STUR) && mem_ready;
      S_WB:    retire_s = 1'b1;
      default: retire_s = 1'b0;
    endcase
  end

  // Sequencer: state, latched instruction class and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      class_r   <= CL_NONE;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (run) state_r <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) state_r <= S_DECODE;
        end
        S_DECODE: begin
          class_r <= dec_s;
          if (dec_s == CL_NONE) begin
            state_r   <= S_ERROR;
            illegal_r <= 1'b1;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (retire_s) begin
            state_r <= run ? S_FETCH : S_IDLE;
          end else if ((class_r == CL_LDUR) || (class_r == CL_STUR)) begin
            state_r <= S_MEM;
          end else if (class_r == CL_RTYPE) begin
            state_r <= S_WB;
          end else begin
            state_r   <= S_ERROR;
            illegal_r <= 1'b1;
          end
        end
        S_MEM: begin
          // Stay until memory responds; loads then write back, stores retire.
          if (retire_s) begin
            state_r <= run ? S_FETCH : S_IDLE;
          end else if (mem_ready) begin
            state_r <= S_WB;
          end
        end
        S_WB: begin
          state_r <= run ? S_FETCH : S_IDLE;
        end
        S_ERROR: begin
          state_r <= S_ERROR;
        end
        default: begin
          // Unused encoding: treat as a fault and lock up.
          state_r   <= S_ERROR;
          illegal_r <= 1'b1;
        end
      endcase
    end
  end

  // Datapath control decode from state, class, mem_ready and zero.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg2loc    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;

    // Operand and ALU controls follow the latched class while an instruction
    // is in flight, so they stay stable across MEM wait cycles.
    if ((state_r == S_DECODE) || (state_r == S_EXEC) ||
        (state_r == S_MEM)    || (state_r == S_WB)) begin
      alu_src = (class_r == CL_LDUR) || (class_r == CL_STUR);
      reg2loc = (class_r == CL_STUR) || (class_r == CL_CBZ);
      case (class_r)
        CL_CBZ:   alu_op = 2'b01;
        CL_RTYPE: alu_op = 2'b10;
        default:  alu_op = 2'b00;
      endcase
    end else begin
      alu_src = 1'b0;
      reg2loc = 1'b0;
      alu_op  = 2'b00;
    end

    case (state_r)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      S_EXEC: begin
        if (class_r == CL_B) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else if (class_r == CL_CBZ) begin
          pc_write = zero;
          pc_src   = 1'b1;
        end else begin
          pc_write = 1'b0;
          pc_src   = 1'b0;
        end
      end
      S_MEM: begin
        mem_read  = (class_r == CL_LDUR);
        mem_write = (class_r == CL_STUR);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_r == CL_LDUR);
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  assign state   = state_r;
  assign illegal = illegal_r;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_count_r;
  logic [31:0] instr_count_r;

  // Performance counters: active cycles and retired instructions (wrap freely).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_r <= 32'd0;
      instr_count_r <= 32'd0;
    end else begin
      if ((state_r != S_IDLE) && (state_r != S_ERROR)) begin
        cycle_count_r <= cycle_count_r + 32'd1;
      end
      if (retire_s) begin
        instr_count_r <= instr_count_r + 32'd1;
      end
    end
  end

  assign cycle_count = cycle_count_r;
  assign instr_count = instr_count_r;
`endif

endmodule
